// File: rtl/inst_fetch_queue_if.sv
// Fetch-to-decode bundle for the instruction fetch queue: enqueue pair, dequeue pair and flush.
// Handshake: a fetch pair is taken at a clock edge when enq_ready=1 and flush=0; the dequeue
// pair presented on deq_* is consumed at a clock edge when deq_pause=0 and flush=0.
interface inst_fetch_queue_if;
    logic        flush;
    logic        enq_valid_0;
    logic        enq_valid_1;
    logic [31:0] enq_inst_0;
    logic [31:0] enq_inst_1;
    logic [31:0] enq_pc_0;
    logic [31:0] enq_pc_1;
    logic        enq_ready;
    logic        deq_pause;
    logic        deq_valid_0;
    logic        deq_valid_1;
    logic [31:0] deq_inst_0;
    logic [31:0] deq_inst_1;
    logic [31:0] deq_pc_0;
    logic [31:0] deq_pc_1;

    modport master (
        output flush, enq_valid_0, enq_valid_1, enq_inst_0, enq_inst_1, enq_pc_0, enq_pc_1,
        output deq_pause,
        input  enq_ready, deq_valid_0, deq_valid_1, deq_inst_0, deq_inst_1, deq_pc_0, deq_pc_1
    );

    modport slave (
        input  flush, enq_valid_0, enq_valid_1, enq_inst_0, enq_inst_1, enq_pc_0, enq_pc_1,
        input  deq_pause,
        output enq_ready, deq_valid_0, deq_valid_1, deq_inst_0, deq_inst_1, deq_pc_0, deq_pc_1
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// 2-wide circular instruction FIFO between fetch and decode, with compaction and flush.
// Optional IQ_PERF_CNT_EN adds saturating full/empty cycle counters.
module inst_fetch_queue #(
    parameter int  DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
`ifdef IQ_PERF_CNT_EN
    output logic [31:0] perf_full_cnt,
    output logic [31:0] perf_empty_cnt,
`endif
    inst_fetch_queue_if.slave bus
);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    logic [31:0]      r_inst [DEPTH];
    logic [31:0]      r_pc   [DEPTH];

    logic [PTR_W-1:0] w_head_p1;
    logic [PTR_W-1:0] w_tail_p1;
    logic [PTR_W:0]   w_count_next;
    logic             w_enq_ready;
    logic             w_enq_fire;
    logic             w_deq_fire;
    logic             w_deq_valid_0;
    logic             w_deq_valid_1;
    logic [1:0]       w_n_enq;
    logic [1:0]       w_n_deq;

    // Readiness looks only at the registered count so fetch never depends on decode timing.
    assign w_enq_ready   = (r_count <= (PTR_W+1)'(DEPTH - 2));
    assign w_enq_fire    = w_enq_ready && !bus.flush;
    assign w_deq_fire    = !bus.deq_pause && !bus.flush;
    assign w_deq_valid_0 = (r_count != '0);
    assign w_deq_valid_1 = (r_count >= (PTR_W+1)'(2));

    assign w_n_enq = w_enq_fire ? ({1'b0, bus.enq_valid_0} + {1'b0, bus.enq_valid_1}) : 2'd0;
    assign w_n_deq = w_deq_fire ? ({1'b0, w_deq_valid_0} + {1'b0, w_deq_valid_1}) : 2'd0;

    assign w_head_p1    = r_head + PTR_W'(1);
    assign w_tail_p1    = r_tail + PTR_W'(1);
    assign w_count_next = r_count + (PTR_W+1)'(w_n_enq) - (PTR_W+1)'(w_n_deq);

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_n_deq);
            r_tail  <= r_tail + PTR_W'(w_n_enq);
            r_count <= w_count_next;
        end
    end

    // A lone slot-1 instruction is compacted into the tail entry so the queue stays dense.
    always_ff @(posedge clk) begin
        if (w_enq_fire) begin
            if (bus.enq_valid_0) begin
                r_inst[r_tail] <= bus.enq_inst_0;
                r_pc[r_tail]   <= bus.enq_pc_0;
                if (bus.enq_valid_1) begin
                    r_inst[w_tail_p1] <= bus.enq_inst_1;
                    r_pc[w_tail_p1]   <= bus.enq_pc_1;
                end
            end else if (bus.enq_valid_1) begin
                r_inst[r_tail] <= bus.enq_inst_1;
                r_pc[r_tail]   <= bus.enq_pc_1;
            end
        end
    end

    assign bus.enq_ready   = w_enq_ready;
    assign bus.deq_valid_0 = w_deq_valid_0;
    assign bus.deq_valid_1 = w_deq_valid_1;
    assign bus.deq_inst_0  = r_inst[r_head];
    assign bus.deq_pc_0    = r_pc[r_head];
    assign bus.deq_inst_1  = r_inst[w_head_p1];
    assign bus.deq_pc_1    = r_pc[w_head_p1];

`ifdef IQ_PERF_CNT_EN
    logic [31:0] r_perf_full;
    logic [31:0] r_perf_empty;

    // Only reset clears these; a flush is a normal pipeline event and must not hide history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_full  <= '0;
            r_perf_empty <= '0;
        end else begin
            if (!w_enq_ready && (r_perf_full != '1)) begin
                r_perf_full <= r_perf_full + 32'd1;
            end
            if ((r_count == '0) && (r_perf_empty != '1)) begin
                r_perf_empty <= r_perf_empty + 32'd1;
            end
        end
    end

    assign perf_full_cnt  = r_perf_full;
    assign perf_empty_cnt = r_perf_empty;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: reset, pass-through, compaction, full/wrap ordering,
// overlapping enqueue/dequeue, flush and (with IQ_PERF_CNT_EN) the perf counters.
module tb_inst_fetch_queue;

    localparam logic [31:0] INST_KEY = 32'hA500_0000;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    logic [31:0] exp_q[$];

    inst_fetch_queue_if bus();

`ifdef IQ_PERF_CNT_EN
    logic [31:0] perf_full_cnt;
    logic [31:0] perf_empty_cnt;
`endif

    inst_fetch_queue #(.DEPTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef IQ_PERF_CNT_EN
        .perf_full_cnt  (perf_full_cnt),
        .perf_empty_cnt (perf_empty_cnt),
`endif
        .bus            (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Driver: present one fetch pair for one edge, recording what the queue should hold.
    task automatic enq(input logic v0, input logic v1, input logic [31:0] p0, input logic [31:0] p1);
        bus.enq_valid_0 = v0;
        bus.enq_valid_1 = v1;
        bus.enq_pc_0    = p0;
        bus.enq_pc_1    = p1;
        bus.enq_inst_0  = p0 ^ INST_KEY;
        bus.enq_inst_1  = p1 ^ INST_KEY;
        if (v0) exp_q.push_back(p0);
        if (v1) exp_q.push_back(p1);
        step();
        bus.enq_valid_0 = 1'b0;
        bus.enq_valid_1 = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.flush       = 1'b0;
        bus.enq_valid_0 = 1'b0;
        bus.enq_valid_1 = 1'b0;
        bus.enq_inst_0  = '0;
        bus.enq_inst_1  = '0;
        bus.enq_pc_0    = '0;
        bus.enq_pc_1    = '0;
        bus.deq_pause   = 1'b1;
    endtask

    // Scoreboard: release pause and compare every dequeued pair against exp_q, bounded.
    task automatic drain(input string tag);
        logic [31:0] e;
        bus.deq_pause = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            check({tag, "_v0"}, {31'd0, bus.deq_valid_0}, 32'd1);
            check({tag, "_pc0"}, bus.deq_pc_0, e);
            check({tag, "_inst0"}, bus.deq_inst_0, e ^ INST_KEY);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({tag, "_v1"}, {31'd0, bus.deq_valid_1}, 32'd1);
                check({tag, "_pc1"}, bus.deq_pc_1, e);
            end else begin
                check({tag, "_v1_last"}, {31'd0, bus.deq_valid_1}, 32'd0);
            end
            step();
        end
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_empty"}, {31'd0, bus.deq_valid_0}, 32'd0);
        bus.deq_pause = 1'b1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        idle_inputs();

        // 1. Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_ready", {31'd0, bus.enq_ready}, 32'd1);
        check("rst_v0", {31'd0, bus.deq_valid_0}, 32'd0);
        check("rst_v1", {31'd0, bus.deq_valid_1}, 32'd0);

        // 2. Pair pass-through under pause
        bus.enq_valid_0 = 1'b1; bus.enq_inst_0 = 32'h2401_0001; bus.enq_pc_0 = 32'h0;
        bus.enq_valid_1 = 1'b1; bus.enq_inst_1 = 32'h2402_0002; bus.enq_pc_1 = 32'h4;
        step();
        idle_inputs();
        check("pair_v0", {31'd0, bus.deq_valid_0}, 32'd1);
        check("pair_v1", {31'd0, bus.deq_valid_1}, 32'd1);
        check("pair_pc0", bus.deq_pc_0, 32'h0);
        check("pair_pc1", bus.deq_pc_1, 32'h4);
        check("pair_inst0", bus.deq_inst_0, 32'h2401_0001);
        check("pair_inst1", bus.deq_inst_1, 32'h2402_0002);
        bus.deq_pause = 1'b0;
        step();
        bus.deq_pause = 1'b1;
        check("pair_drained", {31'd0, bus.deq_valid_0}, 32'd0);

        // 3. Compaction of a lone slot-1 instruction
        bus.enq_valid_1 = 1'b1; bus.enq_inst_1 = 32'h0022_1820; bus.enq_pc_1 = 32'h8;
        step();
        idle_inputs();
        check("cmp_v0", {31'd0, bus.deq_valid_0}, 32'd1);
        check("cmp_inst0", bus.deq_inst_0, 32'h0022_1820);
        check("cmp_pc0", bus.deq_pc_0, 32'h8);
        check("cmp_v1", {31'd0, bus.deq_valid_1}, 32'd0);
        bus.deq_pause = 1'b0;
        step();
        bus.deq_pause = 1'b1;
        check("cmp_drained", {31'd0, bus.deq_valid_0}, 32'd0);

        // 4. Fill to full from index 3 (wraps), extra enqueue ignored, drain in order
        for (int k = 0; k < 8; k++) begin
            enq(1'b1, 1'b1, 32'(16 * k / 2), 32'(16 * k / 2 + 4));
            check("fill_ready", {31'd0, bus.enq_ready}, (k < 7) ? 32'd1 : 32'd0);
        end
        bus.enq_valid_0 = 1'b1; bus.enq_pc_0 = 32'h100; bus.enq_inst_0 = 32'hDEAD_0100;
        bus.enq_valid_1 = 1'b1; bus.enq_pc_1 = 32'h104; bus.enq_inst_1 = 32'hDEAD_0104;
        step();
        idle_inputs();
        check("full_hold_ready", {31'd0, bus.enq_ready}, 32'd0);
        drain("drain1");

        // Refill with singles then pairs so one pair straddles index 15 -> 0
        enq(1'b0, 1'b1, 32'h0, 32'h200);
        enq(1'b1, 1'b0, 32'h204, 32'h0);
        for (int k = 0; k < 7; k++) begin
            enq(1'b1, 1'b1, 32'(32'h208 + 8 * k), 32'(32'h20C + 8 * k));
        end
        check("refill_full", {31'd0, bus.enq_ready}, 32'd0);
        drain("drain2");

        // Overlapping enqueue and dequeue
        bus.deq_pause = 1'b0;
        bus.enq_valid_0 = 1'b1; bus.enq_pc_0 = 32'h300; bus.enq_inst_0 = 32'h300 ^ INST_KEY;
        bus.enq_valid_1 = 1'b1; bus.enq_pc_1 = 32'h304; bus.enq_inst_1 = 32'h304 ^ INST_KEY;
        step();
        check("ovl_pc0_a", bus.deq_pc_0, 32'h300);
        check("ovl_pc1_a", bus.deq_pc_1, 32'h304);
        bus.enq_pc_0 = 32'h308; bus.enq_inst_0 = 32'h308 ^ INST_KEY;
        bus.enq_pc_1 = 32'h30C; bus.enq_inst_1 = 32'h30C ^ INST_KEY;
        step();
        bus.enq_valid_0 = 1'b0;
        bus.enq_valid_1 = 1'b0;
        check("ovl_v1_b", {31'd0, bus.deq_valid_1}, 32'd1);
        check("ovl_pc0_b", bus.deq_pc_0, 32'h308);
        check("ovl_pc1_b", bus.deq_pc_1, 32'h30C);
        step();
        check("ovl_empty", {31'd0, bus.deq_valid_0}, 32'd0);
        bus.deq_pause = 1'b1;

        // 5. Flush with count=6 and a simultaneous enqueue
        for (int k = 0; k < 3; k++) begin
            enq(1'b1, 1'b1, 32'(32'h400 + 8 * k), 32'(32'h404 + 8 * k));
        end
        exp_q.delete();
        bus.flush = 1'b1;
        bus.enq_valid_0 = 1'b1; bus.enq_pc_0 = 32'h500;
        bus.enq_valid_1 = 1'b1; bus.enq_pc_1 = 32'h504;
        step();
        idle_inputs();
        check("flush_v0", {31'd0, bus.deq_valid_0}, 32'd0);
        check("flush_v1", {31'd0, bus.deq_valid_1}, 32'd0);
        check("flush_ready", {31'd0, bus.enq_ready}, 32'd1);
        step();
        check("flush_dropped", {31'd0, bus.deq_valid_0}, 32'd0);
        enq(1'b1, 1'b0, 32'h600, 32'h0);
        drain("post_flush");

`ifdef IQ_PERF_CNT_EN
        // 6. Perf counters: 3 idle cycles, fill, hold full 10 cycles, then flush
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("perf_rst_full", perf_full_cnt, 32'd0);
        step(); step(); step();
        check("perf_empty_idle", {31'd0, (perf_empty_cnt >= 32'd3)}, 32'd1);
        check("perf_empty_3", perf_empty_cnt, 32'd3);
        for (int k = 0; k < 8; k++) begin
            enq(1'b1, 1'b1, 32'(8 * k), 32'(8 * k + 4));
        end
        for (int k = 0; k < 10; k++) step();
        check("perf_full_10", perf_full_cnt, 32'd10);
        check("perf_empty_4", perf_empty_cnt, 32'd4);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        exp_q.delete();
        check("perf_flush_full", perf_full_cnt, 32'd11);
        check("perf_flush_empty", perf_empty_cnt, 32'd4);
        step();
        check("perf_after_full", perf_full_cnt, 32'd11);
        check("perf_after_empty", perf_empty_cnt, 32'd5);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
